// File: rtl/xbar_req_tracker.sv
// -----------------------------------------------------------------------------
// xbar_req_tracker
//
// Per-channel request tracker in front of a crossbar. Each of N_CH master
// channels owns a one-entry request slot (EMPTY/FULL) that registers the
// upstream request. It also owns a counter of granted-but-unanswered
// requests. The slot issues downstream only while the counter is below
// MAX_OUTST. Responses pass through combinationally and decrement the
// counter.
//
// Optional feature (macro XBAR_REQ_TRACKER_ERR_EN):
//   When defined, err_o[c] is a sticky flag. It sets when a response arrives
//   on a channel whose counter is already 0 with no drain in the same cycle.
//   When undefined, err_o is tied to 0 and no flag registers exist.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   m_req_i      in   [N_CH]          upstream request
//   m_pld_i      in   [N_CH*PLD_W]    upstream payload {add,wen,wdata,be,aux}
//   m_gnt_o      out  [N_CH]          upstream grant
//   s_req_o      out  [N_CH]          downstream request (from slot registers)
//   s_pld_o      out  [N_CH*PLD_W]    downstream payload (slot contents)
//   s_gnt_i      in   [N_CH]          downstream grant
//   s_r_valid_i  in   [N_CH]          downstream response valid
//   s_rsp_i      in   [N_CH*RSP_W]    downstream response {rdata,opc,aux}
//   m_r_valid_o  out  [N_CH]          upstream response valid (pass-through)
//   m_rsp_o      out  [N_CH*RSP_W]    upstream response (pass-through)
//   outst_o      out  [N_CH*CNT_W]    per-channel outstanding count
//   err_o        out  [N_CH]          sticky response-underflow flag
// -----------------------------------------------------------------------------
module xbar_req_tracker #(
  parameter int N_CH      = 9,
  parameter int AUX_W     = 8,
  parameter int MAX_OUTST = 4,
  parameter int PLD_W     = 69 + AUX_W,
  parameter int RSP_W     = 40 + AUX_W,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         m_req_i,
  input  logic [N_CH*PLD_W-1:0]   m_pld_i,
  output logic [N_CH-1:0]         m_gnt_o,
  output logic [N_CH-1:0]         s_req_o,
  output logic [N_CH*PLD_W-1:0]   s_pld_o,
  input  logic [N_CH-1:0]         s_gnt_i,
  input  logic [N_CH-1:0]         s_r_valid_i,
  input  logic [N_CH*RSP_W-1:0]   s_rsp_i,
  output logic [N_CH-1:0]         m_r_valid_o,
  output logic [N_CH*RSP_W-1:0]   m_rsp_o,
  output logic [N_CH*CNT_W-1:0]   outst_o,
  output logic [N_CH-1:0]         err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Responses are forwarded with zero latency; the tracker only counts them.
  assign m_r_valid_o = s_r_valid_i;
  assign m_rsp_o     = s_rsp_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    slot_e             slot_q;
    logic [PLD_W-1:0]  pld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              drain;
    logic              accept;
    logic              rsp;

    // A full slot stays silent once the channel has MAX_OUTST requests in flight.
    assign s_req_o[c] = (slot_q == SLOT_FULL) && (cnt_q < MAX_CNT);
    assign drain      = s_req_o[c] & s_gnt_i[c];
    // Grant when empty, or when the slot is leaving this cycle so it can refill
    // without a bubble.
    assign m_gnt_o[c] = (slot_q == SLOT_EMPTY) || drain;
    assign accept     = m_req_i[c] & m_gnt_o[c];
    assign rsp        = s_r_valid_i[c];

    assign s_pld_o[c*PLD_W +: PLD_W] = pld_q;
    assign outst_o[c*CNT_W +: CNT_W] = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= SLOT_EMPTY;
        // NOTE: the payload register is reset as well, so a discarded request can
        // never show up on s_pld_o after reset.
        pld_q  <= '0;
      end else if (accept) begin
        slot_q <= SLOT_FULL;
        pld_q  <= m_pld_i[c*PLD_W +: PLD_W];
      end else if (drain) begin
        slot_q <= SLOT_EMPTY;
      end
    end

    // A drain and a response in the same cycle cancel out. A response with
    // nothing outstanding saturates at 0 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (drain && !rsp) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (rsp && !drain && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

`ifdef XBAR_REQ_TRACKER_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_q <= 1'b0;
      end else if (rsp && !drain && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end

    assign err_o[c] = err_q;
`endif
  end : g_ch

`ifndef XBAR_REQ_TRACKER_ERR_EN
  assign err_o = '0;
`endif

endmodule : xbar_req_tracker

// File: doc/xbar_req_tracker.md
XBAR_REQ_TRACKER -- requirements
Module: xbar_req_tracker

Interface
REQ-001 SHALL have parameter N_CH, default 9, number of independent master channels.
REQ-002 SHALL have parameter AUX_W, default 8, aux field width; PLD_W = 69+AUX_W (add 32, wen 1, wdata 32, be 4, aux), RSP_W = 40+AUX_W (rdata 32, opc 8, aux).
REQ-003 SHALL have parameter MAX_OUTST, default 4, range 1..15, max granted-but-unanswered requests per channel; CNT_W = 4.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 m_req_i  in  N_CH  upstream request per channel.
REQ-007 m_pld_i  in  N_CH*PLD_W  upstream request payload, channel c at [c*PLD_W +: PLD_W].
REQ-008 m_gnt_o  out  N_CH  upstream grant.
REQ-009 s_req_o  out  N_CH  downstream (xbar) request, registered.
REQ-010 s_pld_o  out  N_CH*PLD_W  downstream payload, registered.
REQ-011 s_gnt_i  in  N_CH  downstream grant.
REQ-012 s_r_valid_i  in  N_CH  downstream response valid.
REQ-013 s_rsp_i  in  N_CH*RSP_W  downstream response payload.
REQ-014 m_r_valid_o  out  N_CH  upstream response valid.
REQ-015 m_rsp_o  out  N_CH*RSP_W  upstream response payload.
REQ-016 outst_o  out  N_CH*CNT_W  per-channel outstanding count.
REQ-017 err_o  out  N_CH  sticky response-underflow flag (see Configuration).

Function
REQ-018 Each channel SHALL hold a one-entry request slot, states EMPTY/FULL, and a counter cnt; channels fully independent.
REQ-019 s_req_o[c] SHALL be 1 iff slot FULL and cnt < MAX_OUTST; s_pld_o[c] = slot contents.
REQ-020 m_gnt_o[c] SHALL be 1 when slot EMPTY, or slot FULL and s_req_o[c]&s_gnt_i[c] (drain and refill same cycle); else 0.
REQ-021 Accept (m_req_i&m_gnt_o): slot <- m_pld_i, state FULL; request visible on s_req_o next cycle (1-cycle latency).
REQ-022 Drain (s_req_o&s_gnt_i) without accept: state -> EMPTY; with accept: stays FULL, new payload.
REQ-023 While FULL and not drained, slot payload SHALL not change.
REQ-024 cnt SHALL +1 on drain, -1 on s_r_valid_i, unchanged when both same cycle.
REQ-025 cnt == MAX_OUTST SHALL block s_req_o until a response arrives; blocked slot keeps m_gnt_o low.
REQ-026 s_r_valid_i with cnt == 0 and no same-cycle drain SHALL leave cnt at 0 (no wrap).
REQ-027 m_r_valid_o = s_r_valid_i and m_rsp_o = s_rsp_i, combinational, zero latency.
REQ-028 outst_o SHALL show registered cnt per channel.

Reset
REQ-029 rst_n low SHALL asynchronously force slot EMPTY, payload 0, cnt 0, err_o 0, hence s_req_o 0, m_gnt_o all 1 after release.
REQ-030 Reset mid-operation SHALL discard slot content and counts; late responses after release handled per REQ-026.

Configuration
REQ-031 With XBAR_REQ_TRACKER_ERR_EN defined, err_o[c] SHALL set on the REQ-026 underflow event and hold until reset.
REQ-032 Without XBAR_REQ_TRACKER_ERR_EN, err_o SHALL be tied 0 and no flag registers exist.

Verification
REQ-033 Ch0 m_req_i=1, pld add=0x1000, s_gnt_i=1 -> s_req_o[0]=1 next cycle with add 0x1000, outst_o[0]=1 after grant.
REQ-034 MAX_OUTST=4, s_gnt_i=1, no responses, 6 requests -> 4 drained, 5th held with s_req_o=0, m_gnt_o=0; one r_valid -> 5th issued following cycle.
REQ-035 s_gnt_i=0 for 3 cycles with slot FULL -> s_pld_o stable, m_gnt_o=0; s_gnt_i=1 with new m_req_i -> back-to-back issue, no bubble.
REQ-036 Drain and r_valid same cycle at cnt=2 -> cnt stays 2.
REQ-037 r_valid at cnt=0 -> cnt stays 0; err_o[c]=1 with XBAR_REQ_TRACKER_ERR_EN, 0 without.
REQ-038 rst_n pulsed low while 3 channels FULL, cnt=3 -> all s_req_o=0, outst_o=0 immediately, m_gnt_o=1 after release.
